exe_div_seq: RTL and testbench

//  Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU, alongside the combinational exe ALU.

---
 rtl/exe_div_seq_pkg.sv | 8 +
 rtl/exe_div_seq_div_step.sv | 23 ++
 rtl/exe_div_seq.sv | 116 +++++++++++
 tb/tb_exe_div_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/exe_div_seq_pkg.sv
// exe_div_seq_pkg: divide op codes and sequencer state encoding shared by the divide unit
package exe_div_seq_pkg;
    localparam int OP_DIV  = 'h30;
    localparam int OP_DIVU = 'h31;
    localparam int OP_REM  = 'h32;
    localparam int OP_REMU = 'h33;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} div_state_e;
endpackage

// File: rtl/exe_div_seq_div_step.sv
// exe_div_seq_div_step: one radix-2 restoring divide iteration
//  rem_i/quo_i       current partial remainder and shifting dividend/quotient
//  divisor_i         divisor magnitude
//  rem_o/quo_o       state after one shift/compare/subtract
module exe_div_seq_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    // the top bit of diff is the borrow: set means the divisor did not fit
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        diff    = shifted - {1'b0, divisor_i};
        rem_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_o   = {quo_i[WIDTH-2:0], ~diff[WIDTH]};
    end
endmodule

// File: rtl/exe_div_seq.sv
// exe_div_seq: multi-cycle DIV/DIVU/REM/REMU sequencer beside the exe ALU
//  clk_i, rst_i (async, active-low)
//  aluOp_i, op1_i, op2_i, reg_waddr_i, reg_we_i   divide request from id_exe
//  flush_i                                       abort any divide in flight
//  stall_req_o                                   hold IF..EXE while dividing
//  done_o, reg_waddr_o, reg_we_o, reg_wdata_o    one-cycle result write port
module exe_div_seq
    import exe_div_seq_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int OP_W   = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [OP_W-1:0]   aluOp_i,
    input  logic [WIDTH-1:0]  op1_i,
    input  logic [WIDTH-1:0]  op2_i,
    input  logic [ADDR_W-1:0] reg_waddr_i,
    input  logic              reg_we_i,
    input  logic              flush_i,
    output logic              stall_req_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] reg_waddr_o,
    output logic              reg_we_o,
    output logic [WIDTH-1:0]  reg_wdata_o
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  rem, quo, dvsr, rem_nxt, quo_nxt;
    logic [WIDTH-1:0]  op1_abs, op2_abs, quo_fix, rem_fix;
    logic [ADDR_W-1:0] waddr;
    logic              is_div_op, is_signed_op, is_rem_op, start;
    logic              is_rem, neg_q, neg_r, we;

    assign is_div_op    = aluOp_i inside {OP_W'(OP_DIV), OP_W'(OP_DIVU), OP_W'(OP_REM), OP_W'(OP_REMU)};
    assign is_signed_op = aluOp_i == OP_W'(OP_DIV) || aluOp_i == OP_W'(OP_REM);
    assign is_rem_op    = aluOp_i == OP_W'(OP_REM) || aluOp_i == OP_W'(OP_REMU);
    // start is gated by rst_i so a divide op held during reset cannot raise a stall
    assign start        = rst_i && state == S_IDLE && is_div_op && !flush_i;
    assign stall_req_o  = start || state == S_CALC;
    // magnitude of -2^(W-1) negates to itself and is read as unsigned
    assign op1_abs      = (is_signed_op && op1_i[WIDTH-1]) ? -op1_i : op1_i;
    assign op2_abs      = (is_signed_op && op2_i[WIDTH-1]) ? -op2_i : op2_i;
    assign quo_fix      = neg_q ? -quo : quo;
    assign rem_fix      = neg_r ? -rem : rem;
    assign done_o       = state == S_DONE && !flush_i;
    assign reg_we_o     = done_o && we;
    assign reg_waddr_o  = done_o ? waddr : '0;
    assign reg_wdata_o  = done_o ? (is_rem ? rem_fix : quo_fix) : '0;

    exe_div_seq_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i    (rem),
        .quo_i    (quo),
        .divisor_i(dvsr),
        .rem_o    (rem_nxt),
        .quo_o    (quo_nxt)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= S_IDLE;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            waddr  <= '0;
            we     <= 1'b0;
            is_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (flush_i) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    is_rem <= is_rem_op;
                    waddr  <= reg_waddr_i;
                    we     <= reg_we_i;
                    cnt    <= '0;
                    // special cases load the final result directly, no sign fix-up
                    if (op2_i == '0) begin
                        quo   <= '1;
                        rem   <= op1_i;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                        state <= S_DONE;
                    end else if (is_signed_op && op1_i == MIN_NEG && op2_i == '1) begin
                        quo   <= op1_i;
                        rem   <= '0;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        quo   <= op1_abs;
                        rem   <= '0;
                        dvsr  <= op2_abs;
                        neg_q <= is_signed_op && (op1_i[WIDTH-1] ^ op2_i[WIDTH-1]);
                        neg_r <= is_signed_op && op1_i[WIDTH-1];
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    rem   <= rem_nxt;
                    quo   <= quo_nxt;
                    cnt   <= cnt + 1'b1;
                    state <= cnt == CNT_W'(WIDTH - 1) ? S_DONE : S_CALC;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exe_div_seq.sv
// tb_exe_div_seq: directed table, corner sequences and random ops against an arithmetic model
module tb_exe_div_seq;
    import exe_div_seq_pkg::*;

    localparam logic [7:0] DIV  = 8'(OP_DIV);
    localparam logic [7:0] DIVU = 8'(OP_DIVU);
    localparam logic [7:0] REM  = 8'(OP_REM);
    localparam logic [7:0] REMU = 8'(OP_REMU);
    localparam logic [7:0] ORI  = 8'h05;
    localparam logic [7:0] NOP  = 8'h00;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [7:0]  aluOp_i = NOP;
    logic [31:0] op1_i = '0, op2_i = '0;
    logic [4:0]  reg_waddr_i = '0;
    logic        reg_we_i = 1'b0, flush_i = 1'b0;
    logic        stall_req_o, done_o, reg_we_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;

    int checks = 0;
    int errors = 0;

    exe_div_seq dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .aluOp_i    (aluOp_i),
        .op1_i      (op1_i),
        .op2_i      (op2_i),
        .reg_waddr_i(reg_waddr_i),
        .reg_we_i   (reg_we_i),
        .flush_i    (flush_i),
        .stall_req_o(stall_req_o),
        .done_o     (done_o),
        .reg_waddr_o(reg_waddr_o),
        .reg_we_o   (reg_we_o),
        .reg_wdata_o(reg_wdata_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // RISC-V M-extension semantics from plain 64-bit arithmetic
    function automatic logic [31:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        bit sgn = op == DIV || op == REM;
        bit rm  = op == REM || op == REMU;
        longint sa = sgn ? longint'($signed(a)) : longint'(a);
        longint sb = sgn ? longint'($signed(b)) : longint'(b);
        if (b == 0) return rm ? a : 32'hFFFF_FFFF;
        return rm ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    function automatic int model_lat(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        bit sgn = op == DIV || op == REM;
        return (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
    endfunction

    // called on a falling edge; returns on the falling edge after done_o
    task automatic run_chk(input string nm, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] wa, input logic we, input logic [31:0] exp, input int elat);
        int lat = -1;
        int st = 0;
        logic [31:0] d = '0;
        logic [4:0] ad = '0;
        logic ow = 1'b0, sd = 1'b1;
        aluOp_i = op; op1_i = a; op2_i = b; reg_waddr_i = wa; reg_we_i = we;
        #1;
        for (int c = 0; c < 60; c++) begin
            if (done_o) begin
                lat = c; d = reg_wdata_o; ad = reg_waddr_o; ow = reg_we_o; sd = stall_req_o;
                break;
            end
            if (stall_req_o) st++;
            @(negedge clk_i); #1;
        end
        chk({nm, "_data"}, d, exp);
        chk({nm, "_waddr"}, 32'(ad), 32'(wa));
        chk({nm, "_we"}, 32'(ow), 32'(we));
        chk({nm, "_latency"}, 32'(lat), 32'(elat));
        chk({nm, "_stall_cycles"}, 32'(st), 32'(elat));
        chk({nm, "_stall_at_done"}, 32'(sd), 32'd0);
        @(negedge clk_i);
        aluOp_i = NOP;
    endtask

    typedef struct {
        string       nm;
        logic [7:0]  op;
        logic [31:0] a, b, exp;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cnt_stall, cnt_done;
        vecs[0]  = '{"divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 33};
        vecs[1]  = '{"remu_100_7", REMU, 32'd100, 32'd7, 32'd2, 33};
        vecs[2]  = '{"div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33};
        vecs[3]  = '{"rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{"div_by0", DIV, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1};
        vecs[5]  = '{"rem_5_by0", REM, 32'd5, 32'd0, 32'd5, 1};
        vecs[6]  = '{"div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[7]  = '{"rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1};
        vecs[8]  = '{"divu_min_m1", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33};
        vecs[9]  = '{"rem_m5_by0", REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1};
        vecs[10] = '{"div_7_m2", DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};

        aluOp_i = DIVU; op1_i = 32'd100; op2_i = 32'd7;
        repeat (2) @(negedge clk_i);
        chk("reset_stall", 32'(stall_req_o), 0);
        chk("reset_done", 32'(done_o), 0);
        chk("reset_we", 32'(reg_we_o), 0);
        chk("reset_waddr", 32'(reg_waddr_o), 0);
        chk("reset_wdata", reg_wdata_o, 0);
        aluOp_i = NOP;
        rst_i = 1'b1;
        @(negedge clk_i);

        foreach (vecs[i])
            run_chk(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), 1'b1, vecs[i].exp, vecs[i].lat);

        aluOp_i = ORI; op1_i = 32'd100; op2_i = 32'd7;
        cnt_stall = 0; cnt_done = 0;
        repeat (10) begin
            #1;
            if (stall_req_o) cnt_stall++;
            if (done_o || reg_we_o) cnt_done++;
            @(negedge clk_i);
        end
        chk("ori_stall", 32'(cnt_stall), 0);
        chk("ori_done", 32'(cnt_done), 0);
        aluOp_i = NOP;

        aluOp_i = DIVU; op1_i = 32'd1000; op2_i = 32'd3; reg_waddr_i = 5'd9; reg_we_i = 1'b1;
        repeat (11) @(negedge clk_i);
        flush_i = 1'b1;
        #1;
        chk("flush_done_now", 32'(done_o), 0);
        @(negedge clk_i);
        flush_i = 1'b0; aluOp_i = NOP;
        #1;
        chk("flush_idle_stall", 32'(stall_req_o), 0);
        cnt_done = 0;
        repeat (40) begin
            @(negedge clk_i); #1;
            if (done_o || reg_we_o || stall_req_o) cnt_done++;
        end
        chk("flush_no_result", 32'(cnt_done), 0);
        @(negedge clk_i);
        run_chk("divu_9_3_after_flush", DIVU, 32'd9, 32'd3, 5'd4, 1'b1, 32'd3, 33);

        aluOp_i = DIVU; op1_i = 32'd1000; op2_i = 32'd3; reg_waddr_i = 5'd11; reg_we_i = 1'b1;
        repeat (6) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("arst_stall", 32'(stall_req_o), 0);
        chk("arst_done", 32'(done_o), 0);
        chk("arst_we", 32'(reg_we_o), 0);
        chk("arst_wdata", reg_wdata_o, 0);
        @(negedge clk_i);
        aluOp_i = NOP; rst_i = 1'b1;
        #1;
        chk("arst_release_stall", 32'(stall_req_o), 0);
        @(negedge clk_i);
        run_chk("divu_50_5_after_rst", DIVU, 32'd50, 32'd5, 5'd12, 1'b1, 32'd10, 33);

        run_chk("b2b_divu", DIVU, 32'hFFFF_FFFF, 32'd1, 5'd3, 1'b1, 32'hFFFF_FFFF, 33);
        run_chk("b2b_remu", REMU, 32'd10, 32'd3, 5'd7, 1'b1, 32'd1, 33);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] op;
            logic [31:0] a, b;
            logic [4:0] wa;
            logic we;
            case ($urandom_range(0, 3))
                0: op = DIV;
                1: op = DIVU;
                2: op = REM;
                default: op = REMU;
            endcase
            a = pick(); b = pick();
            wa = 5'($urandom); we = 1'($urandom);
            run_chk($sformatf("rand%0d", i), op, a, b, wa, we, model(op, a, b), model_lat(op, a, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
